// File: rtl/updn_ctr_pkg.sv
//------------------------------------------------------------------------------
// Module   : updn_ctr_pkg
// Purpose  : Shared constants for the up/down counter slice: default width,
//            direction encodings and the load-active level.
// Ports    : none (package)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package updn_ctr_pkg;

   // Default counter / data width in bits
   localparam int DEFAULT_WIDTH = 4;

   // Direction encodings on up_dn
   localparam logic UP = 1'b1;
   localparam logic DN = 1'b0;

   // Level of the load pin that selects a parallel load
   localparam logic LOAD_ACT = 1'b0;

endpackage : updn_ctr_pkg

`default_nettype wire

// File: rtl/updn_ctr_if.sv
//------------------------------------------------------------------------------
// Module   : updn_ctr_if
// Purpose  : Bundles the control, data and status signals of updn_ctr.
// Ports    : data, up_dn, load, cen  - driven by the controlling block
//            count, tercnt           - driven by the counter
//            modport master : controlling block view
//            modport slave  : counter view
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface updn_ctr_if
   import updn_ctr_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH
);

   logic [width-1:0] data;
   logic             up_dn;
   logic             load;
   logic             cen;
   logic [width-1:0] count;
   logic             tercnt;

   modport master (
      output data,
      output up_dn,
      output load,
      output cen,
      input  count,
      input  tercnt
   );

   modport slave (
      input  data,
      input  up_dn,
      input  load,
      input  cen,
      output count,
      output tercnt
   );

endinterface : updn_ctr_if

`default_nettype wire

// File: rtl/updn_ctr_tc_decode.sv
//------------------------------------------------------------------------------
// Module   : updn_ctr_tc_decode
// Purpose  : Combinational terminal-count decode. Flags all-ones when counting
//            up and all-zeros when counting down.
// Ports    : count  (in,  width) current counter value
//            up_dn  (in,  1)     direction, 1 = up
//            tercnt (out, 1)     terminal-count flag
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module updn_ctr_tc_decode
   import updn_ctr_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH
) (
   input  wire logic [width-1:0] count,
   input  wire logic             up_dn,
   output logic                  tercnt
);

   logic w_all_ones;
   logic w_all_zeros;

   assign w_all_ones  = &count;
   assign w_all_zeros = ~|count;

   assign tercnt = (up_dn == UP) ? w_all_ones : w_all_zeros;

endmodule : updn_ctr_tc_decode

`default_nettype wire

// File: rtl/updn_ctr.sv
//------------------------------------------------------------------------------
// Module   : updn_ctr
// Purpose  : Parameterised synchronous binary up/down counter with active-low
//            parallel load, count enable and combinational terminal count.
//            Priority per edge: reset > load > count (up/down) > hold.
//            Wraps modulo 2^width in both directions.
// Ports    : clk          (in)  rising-edge clock
//            reset        (in)  synchronous active-high reset
//            bus (slave)  data/up_dn/load/cen in, count/tercnt out
// Config   : UPDN_CTR_ASSERT_EN - when defined, compiles in simulation-only
//            assertions (width range, X/Z on controls, tercnt decode,
//            +/-1 step). Functional behaviour is unchanged.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module updn_ctr
   import updn_ctr_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH
) (
   input  wire logic  clk,
   input  wire logic  reset,
   updn_ctr_if.slave  bus
);

   logic [width-1:0] r_count;
   logic [width-1:0] w_count_nxt;
   logic             w_tercnt;

   // Next-state mux; reset is handled in the register itself
   always_comb begin
      w_count_nxt = r_count;
      if (bus.load == LOAD_ACT) begin
         w_count_nxt = bus.data;
      end else if (bus.cen) begin
         // Carry/borrow out of the MSB is dropped, giving modulo wrap
         if (bus.up_dn == UP) begin
            w_count_nxt = r_count + 1'b1;
         end else begin
            w_count_nxt = r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   updn_ctr_tc_decode #(
      .width (width)
   ) u_tc_decode (
      .count  (r_count),
      .up_dn  (bus.up_dn),
      .tercnt (w_tercnt)
   );

   assign bus.count  = r_count;
   assign bus.tercnt = w_tercnt;

`ifdef UPDN_CTR_ASSERT_EN
   // Set by the first reset; input checks are meaningless before that
   logic r_seen_rst;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seen_rst <= 1'b1;
      end
   end

   a_width_range : assert property (@(posedge clk) (width >= 1) && (width <= 32))
      else $error("updn_ctr: width %0d outside 1..32", width);

   a_ctrl_known : assert property (@(posedge clk) disable iff (reset || (r_seen_rst !== 1'b1))
      !$isunknown({bus.load, bus.cen, bus.up_dn}))
      else $error("updn_ctr: X/Z on load/cen/up_dn");

   a_data_known : assert property (@(posedge clk) disable iff (reset || (r_seen_rst !== 1'b1))
      (bus.load == LOAD_ACT) |-> !$isunknown(bus.data))
      else $error("updn_ctr: X/Z on data during load");

   a_tercnt_decode : assert property (@(posedge clk)
      bus.tercnt == ((bus.up_dn == UP) ? (r_count == {width{1'b1}}) : (r_count == {width{1'b0}})))
      else $error("updn_ctr: tercnt decode mismatch");

   a_step : assert property (@(posedge clk) disable iff (reset)
      (bus.load != LOAD_ACT) |=> ((r_count == $past(r_count)) ||
                                  (r_count == $past(r_count) + 1'b1) ||
                                  (r_count == $past(r_count) - 1'b1)))
      else $error("updn_ctr: count stepped by more than one");
`endif

endmodule : updn_ctr

`default_nettype wire

// File: tb/tb_updn_ctr.sv
//------------------------------------------------------------------------------
// Module   : tb_updn_ctr
// Purpose  : Self-checking bench for updn_ctr (width = 4). Directed vectors
//            push their hand-computed expected count/tercnt into a queue; a
//            monitor pops and compares one entry just after each rising edge.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_updn_ctr;

   localparam int W = 4;

   logic clk;
   logic reset;

   updn_ctr_if #(.width(W)) bus ();

   updn_ctr #(.width(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic         tc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // Drive one vector at the falling edge; its expected result becomes
   // visible after the following rising edge.
   task automatic drive(input logic rst_v, input logic ld, input logic cn,
                        input logic ud, input logic [W-1:0] d,
                        input logic [W-1:0] e_cnt, input logic e_tc,
                        input string nm);
      exp_t e;
      reset     = rst_v;
      bus.load  = ld;
      bus.cen   = cn;
      bus.up_dn = ud;
      bus.data  = d;
      e.cnt = e_cnt;
      e.tc  = e_tc;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
   endtask

   // Monitor: compare just after every rising edge
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (bus.count !== e.cnt || bus.tercnt !== e.tc) begin
               n_bad++;
               $display("FAIL %s: count=%0d tercnt=%0b expected count=%0d tercnt=%0b",
                        nm, bus.count, bus.tercnt, e.cnt, e.tc);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] e;

      // Reset with load inactive, counting disabled, direction up
      drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'd0, 1'b0, "reset");

      // Direction change alone must flip tercnt without a clock edge
      bus.up_dn = 1'b0;
      #1;
      n_cmp++;
      if (bus.count !== 4'd0 || bus.tercnt !== 1'b1) begin
         n_bad++;
         $display("FAIL tercnt_comb: count=%0d tercnt=%0b expected count=0 tercnt=1",
                  bus.count, bus.tercnt);
      end

      // Parallel load of 7, held for 5 cycles
      for (int i = 0; i < 5; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 4'd7, 1'b0, "load7");

      // Count up from 7: 8..15, 0..6
      for (int i = 1; i <= 15; i++) begin
         e = 4'(7 + i);
         drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, e, (e == 4'd15), "count_up");
      end

      // Count down from 6: 5..0, 15..7
      for (int i = 1; i <= 15; i++) begin
         e = 4'(6 - i);
         drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, e, (e == 4'd0), "count_dn");
      end

      // Load beats an enabled count
      for (int i = 0; i < 4; i++)
         drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 4'd7, 1'b0, "load_over_cen");

      // Reset beats load
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 4'd0, 1'b0, "reset_over_load");

      // Counting resumes on the first edge after reset deasserts
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd1, 1'b0, "resume_after_reset");

      // Hold at 9 for both directions
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 4'd9, 1'b0, "load9");
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'd9, 1'b0, "hold_up");
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd9, 1'b0, "hold_dn");
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'd9, 1'b0, "hold_up2");

      // Terminal count at all-ones while held, then direction change on an
      // enabled edge takes effect immediately
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'd15, 1'b1, "load15_tc");
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd14, 1'b0, "dir_change_dn");

      // Down-direction terminal count at zero, then borrow wrap
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b1, "load0_tc_dn");
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd15, 1'b0, "wrap_dn");
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0, 1'b0, "wrap_up");

      // Idle and let the monitor drain the queue
      reset    = 1'b0;
      bus.load = 1'b1;
      bus.cen  = 1'b0;
      repeat (3) @(negedge clk);

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_updn_ctr

`default_nettype wire

// File: doc/updn_ctr.md
# updn_ctr

Parameterised synchronous binary up/down counter with parallel load, count enable and a combinational terminal-count flag. It is a general-purpose sequencing/timer primitive instantiated wherever a loadable, bidirectional modulo-2^width counter is needed. It is compatible in port naming with the DW03_updn_ctr footprint, except for the reset polarity and synchronicity defined below.

## Interface
- Clocking and reset: one clock; reset is synchronous and active-high.
- Parameters:
  - width, default 4: counter and data width in bits; legal range 1–32.
- Ports:
  - clk  input  1  rising-edge clock.
  - reset  input  1  synchronous active-high reset.
  - data  input  width  parallel load value.
  - up_dn  input  1  direction; 1 = count up, 0 = count down.
  - load  input  1  active-low synchronous load; 0 = load data.
  - cen  input  1  active-high count enable.
  - count  output  width  registered counter value.
  - tercnt  output  1  terminal-count flag, combinational from count and up_dn.

## Operation
- Priority at each rising clk edge, highest first:
  - reset = 1: count ← 0.
  - load = 0: count ← data. Load is independent of cen and up_dn.
  - cen = 1 and up_dn = 1: count ← count + 1, modulo 2^width.
  - cen = 1 and up_dn = 0: count ← count − 1, modulo 2^width.
  - Otherwise: count holds.
- Wrap-around:
  - Up from 2^width−1 gives 0.
  - Down from 0 gives 2^width−1.
  - No saturation and no carry output.
- tercnt:
  - up_dn = 1: tercnt = 1 when count equals all ones.
  - up_dn = 0: tercnt = 1 when count equals all zeros.
  - Otherwise tercnt = 0. tercnt does not depend on cen or load.
- Arithmetic is unsigned, width bits. Carries out of the MSB are discarded.

## Timing
- count updates only on the rising clk edge. Load, increment and decrement each have 1-cycle latency.
- tercnt is combinational:
  - It tracks count in the same cycle.
  - A change of up_dn changes tercnt immediately, with no clock needed.
- Reset values: count = 0. tercnt = 0 when up_dn = 1, and tercnt = 1 when up_dn = 0, because count is 0.
- Reset asserted mid-count overrides load and cen on that edge. Counting resumes on the first edge after reset deasserts, if enabled.
- Simultaneous load = 0 and cen = 1: the load wins, with no count applied that cycle.
- Direction change with cen = 1: the new direction applies on that same edge.

## Configuration
- Macro: UPDN_CTR_ASSERT_EN.
- Defined: simulation-only assertions are compiled in.
  - Elaboration check that width is in 1–32.
  - After reset deasserts, no X/Z on load, cen, up_dn, or on data while load = 0.
  - tercnt equals its decode equation every cycle.
  - count steps by exactly ±1 modulo 2^width (or holds) whenever reset = 0 and load = 1.
- Undefined: no assertion logic. Functional behaviour is identical.

## Structure
- Package updn_ctr_pkg holds:
  - the default width constant (4);
  - named direction constants UP = 1'b1 and DN = 1'b0;
  - the load-active level constant LOAD_ACT = 1'b0.
- One sub-module is natural: updn_ctr_tc_decode.
  - Combinational; inputs count and up_dn; output tercnt.
  - Parameterised by width.
- Keep the count register and next-state mux in the top module.

## Test plan
- Reset: width = 4, hold reset = 1 for 1 cycle with load = 1, cen = 0 -> count = 0, tercnt = 0 with up_dn = 1. Set up_dn = 0 -> tercnt = 1 with no clock edge.
- Load: reset = 0, load = 0, data = 4'h7, cen = 0 for 5 cycles -> count = 7 from the first edge and held; tercnt = 0.
- Count up with wrap: from 7, load = 1, cen = 1, up_dn = 1 for 15 cycles -> count runs 8…15, 0…6. tercnt = 1 exactly in the cycle where count = 15.
- Count down with wrap: then up_dn = 0 for 15 cycles -> count runs 5,4…0,15…7. tercnt = 1 exactly in the cycle where count = 0.
- Load overrides count: cen = 1, up_dn = 1, load = 0, data = 7 for several cycles -> count stays 7. Also pulse reset = 1 with load = 0 -> count = 0 on that edge.
- Hold: cen = 0, load = 1 at count = 9 -> count remains 9 for any up_dn value.
